// File: rtl/block_nest_pkg.sv
// ============================================================================
// block_nest_pkg : shared types and codes for the begin/end fork/join checker
// Revision: 1.0
// ============================================================================
`default_nettype none

package block_nest_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_B, ST_BE, ST_BEG, ST_BEGI, ST_BEGIN,
        ST_E, ST_EN, ST_END,
        ST_F, ST_FO, ST_FOR, ST_FORK,
        ST_J, ST_JO, ST_JOI, ST_JOIN,
        ST_OTHER
    } match_state_t;

    localparam logic KW_BEGIN_END = 1'b0;
    localparam logic KW_FORK_JOIN = 1'b1;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_MISMATCH  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic logic [7:0] to_lower(input logic [7:0] ch);
        if (ch >= 8'h41 && ch <= 8'h5A) begin
            return ch | 8'h20;
        end
        return ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/block_word_matcher.sv
// ============================================================================
// block_word_matcher : case-insensitive keyword recogniser for the current word
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_word_matcher
    import block_nest_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       is_open,
    output logic       is_close,
    output logic       kw_type
);

    match_state_t state;
    match_state_t state_next;
    logic [7:0]   ch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        ch         = to_lower(in);
        state_next = state;
        if (in_valid) begin
            if (in == CHAR_SPACE) begin
                state_next = ST_IDLE;
            end else begin
                // anything that does not extend a keyword prefix poisons the word
                state_next = ST_OTHER;
                case (state)
                    ST_IDLE: begin
                        if (ch == "b") state_next = ST_B;
                        else if (ch == "e") state_next = ST_E;
                        else if (ch == "f") state_next = ST_F;
                        else if (ch == "j") state_next = ST_J;
                    end
                    ST_B:    if (ch == "e") state_next = ST_BE;
                    ST_BE:   if (ch == "g") state_next = ST_BEG;
                    ST_BEG:  if (ch == "i") state_next = ST_BEGI;
                    ST_BEGI: if (ch == "n") state_next = ST_BEGIN;
                    ST_E:    if (ch == "n") state_next = ST_EN;
                    ST_EN:   if (ch == "d") state_next = ST_END;
                    ST_F:    if (ch == "o") state_next = ST_FO;
                    ST_FO:   if (ch == "r") state_next = ST_FOR;
                    ST_FOR:  if (ch == "k") state_next = ST_FORK;
                    ST_J:    if (ch == "o") state_next = ST_JO;
                    ST_JO:   if (ch == "i") state_next = ST_JOI;
                    ST_JOI:  if (ch == "n") state_next = ST_JOIN;
                    default: state_next = ST_OTHER;
                endcase
            end
        end
    end

    assign is_open  = (state == ST_BEGIN) || (state == ST_FORK);
    assign is_close = (state == ST_END)   || (state == ST_JOIN);
    assign kw_type  = ((state == ST_FORK) || (state == ST_JOIN)) ? KW_FORK_JOIN : KW_BEGIN_END;

endmodule

`default_nettype wire

// File: rtl/block_nest_checker.sv
// ============================================================================
// block_nest_checker : streaming begin/end and fork/join nesting checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_nest_checker
    import block_nest_pkg::*;
#(
    parameter  int MAX_DEPTH = 16,
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic [1:0]         err_code
);

    logic                 is_open;
    logic                 is_close;
    logic                 kw_type;
    logic [MAX_DEPTH-1:0] stack;
    logic                 top_type;
    logic                 commit;
    logic                 at_empty;
    logic                 at_full;
    logic                 push;
    logic                 pop;
    logic                 set_err;
    logic [1:0]           new_code;

    block_word_matcher u_matcher (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in),
        .is_open  (is_open),
        .is_close (is_close),
        .kw_type  (kw_type)
    );

    assign commit   = in_valid && (in == CHAR_SPACE) && !error;
    assign at_empty = (depth == '0);
    assign at_full  = (depth == DEPTH_W'(MAX_DEPTH));

    always_comb begin
        top_type = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (depth == DEPTH_W'(i + 1)) top_type = stack[i];
        end
    end

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        set_err  = 1'b0;
        new_code = ERR_NONE;
        if (commit) begin
            if (is_open) begin
                if (at_full) begin
                    set_err  = 1'b1;
                    new_code = ERR_OVERFLOW;
                end else begin
                    push = 1'b1;
                end
            end else if (is_close) begin
                if (at_empty) begin
                    set_err  = 1'b1;
                    new_code = ERR_UNDERFLOW;
                end else if (kw_type != top_type) begin
                    set_err  = 1'b1;
                    new_code = ERR_MISMATCH;
                end else begin
                    pop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth    <= '0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (push) begin
                depth <= depth + DEPTH_W'(1);
            end else if (pop) begin
                depth <= depth - DEPTH_W'(1);
            end
            if (set_err) begin
                error    <= 1'b1;
                err_code <= new_code;
            end
        end
    end

    // entry i holds the type of the (i+1)-th open block
    for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stack
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stack[i] <= 1'b0;
            end else if (push && (depth == DEPTH_W'(i))) begin
                stack[i] <= kw_type;
            end
        end
    end

    always_comb begin
        result = 1'b0;
        if (error) begin
            result = 1'b0;
        end else if (is_open) begin
            result = 1'b0;
        end else if (is_close) begin
            result = (depth == DEPTH_W'(1)) && (kw_type == top_type);
        end else begin
            result = at_empty;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_nest_checker.sv
// ============================================================================
// tb_block_nest_checker : directed table-driven bench for block_nest_checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_block_nest_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in;

    logic       result;
    logic [4:0] depth;
    logic       error;
    logic [1:0] err_code;

    logic       result2;
    logic [1:0] depth2;
    logic       error2;
    logic [1:0] err_code2;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        bit    rst;
        string s;
        bit    v;
        int    d;
        bit    r;
        bit    e;
        int    c;
    } vec_t;

    vec_t vq[$];

    block_nest_checker dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in),
        .result   (result),
        .depth    (depth),
        .error    (error),
        .err_code (err_code)
    );

    block_nest_checker #(.MAX_DEPTH(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in),
        .result   (result2),
        .depth    (depth2),
        .error    (error2),
        .err_code (err_code2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void add(input bit rst, input string s, input bit v,
                                input int d, input bit r, input bit e, input int c);
        vec_t t;
        t.rst = rst; t.s = s; t.v = v; t.d = d; t.r = r; t.e = e; t.c = c;
        vq.push_back(t);
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic send_word(input string s, input bit v);
        for (int k = 0; k < s.len(); k++) begin
            in       = s[k];
            in_valid = v;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in        = 8'h00;
        #12;
        reset = 1'b1;

        //  rst  text          v  depth res err code
        add(1, "",             1, 0, 1, 0, 0);
        add(0, "Begin ",       1, 1, 0, 0, 0);
        add(0, "fork ",        1, 2, 0, 0, 0);
        add(0, "JOIN ",        1, 1, 0, 0, 0);
        add(0, "end ",         1, 0, 1, 0, 0);
        add(1, "begin fork ",  1, 2, 0, 0, 0);
        add(0, "end ",         1, 2, 0, 1, 2);
        add(0, "join ",        1, 2, 0, 1, 2);
        add(1, "end ",         1, 0, 0, 1, 1);
        add(1, "begin en",     1, 1, 0, 0, 0);
        add(0, " ",            1, 1, 0, 0, 0);
        add(1, "beginx ",      1, 0, 1, 0, 0);
        add(1, "begin end",    1, 1, 1, 0, 0);
        add(0, " ",            0, 1, 1, 0, 0);
        add(0, " ",            1, 0, 1, 0, 0);
        add(0, "FoRk JoIn ",   1, 0, 1, 0, 0);
        add(0, "fork",         1, 0, 0, 0, 0);
        add(0, "  ",           1, 1, 0, 0, 0);
        add(0, "join",         1, 1, 1, 0, 0);
        add(0, "   ",          1, 0, 1, 0, 0);
        add(1, "fork end ",    1, 1, 0, 1, 2);

        foreach (vq[i]) begin
            if (vq[i].rst) pulse_reset();
            send_word(vq[i].s, vq[i].v);
            check($sformatf("vec%0d depth", i),    int'(depth),    vq[i].d);
            check($sformatf("vec%0d result", i),   int'(result),   int'(vq[i].r));
            check($sformatf("vec%0d error", i),    int'(error),    int'(vq[i].e));
            check($sformatf("vec%0d err_code", i), int'(err_code), vq[i].c);
        end

        // overflow on the 2-deep instance while the 16-deep one keeps going
        pulse_reset();
        send_word("begin begin ", 1);
        check("ovf2 pre depth", int'(depth2), 2);
        check("ovf2 pre error", int'(error2), 0);
        send_word("begin ", 1);
        check("ovf2 depth",    int'(depth2),    2);
        check("ovf2 error",    int'(error2),    1);
        check("ovf2 err_code", int'(err_code2), 3);
        check("ovf2 result",   int'(result2),   0);
        check("deep3 depth",   int'(depth),     3);

        // asynchronous reset mid-stream, sampled before any clock edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async depth",  int'(depth),  0);
        check("async error",  int'(error),  0);
        check("async result", int'(result), 1);
        check("async error2", int'(error2), 0);
        #2;
        reset = 1'b1;

        // fill the default-depth stack exactly, then one more opener
        for (int n = 0; n < 16; n++) send_word("fork ", 1);
        check("full depth", int'(depth), 16);
        check("full error", int'(error), 0);
        send_word("begin ", 1);
        check("over depth",    int'(depth),    16);
        check("over err_code", int'(err_code), 3);
        check("over error",    int'(error),    1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/block_nest_checker.md
BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

Interface
REQ-001 SHALL have parameter MAX_DEPTH, default 16, meaning the maximum nesting depth held on the pair-type stack (legal range 1..255).
REQ-002 SHALL have localparam DEPTH_W, defined as $clog2(MAX_DEPTH+1), meaning the width of the depth count.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  qualifies in; when low the character is ignored and no state changes.
REQ-006 SHALL have port in  input  8  ASCII character; " " (0x20) is the only separator.
REQ-007 SHALL have port result  output  1  combinational: the stream is balanced if the current word were terminated now.
REQ-008 SHALL have port depth  output  DEPTH_W  the committed count of open blocks.
REQ-009 SHALL have port error  output  1  sticky error flag.
REQ-010 SHALL have port err_code  output  2  encoded as 00 none, 01 underflow, 10 type mismatch, 11 overflow.

Function
REQ-011 SHALL define a word as a maximal run of accepted non-space characters, with keyword matching case-insensitive.
REQ-012 SHALL recognise openers "begin" (type 0) and "fork" (type 1), and closers "end" (type 0) and "join" (type 1); any other word, including prefixes and extensions such as "beginx" or "en", SHALL be neutral.
REQ-013 SHALL use word-matcher states IDLE, B, BE, BEG, BEGI, BEGIN, E, EN, END, F, FO, FOR, FORK, J, JO, JOI, JOIN and OTHER; IDLE is entered on a space, and any character that does not extend a keyword prefix SHALL enter OTHER.
REQ-014 SHALL recognise a new word starting from IDLE, since a space resets the matcher, so consecutive spaces are harmless.
REQ-015 SHALL commit a word in the cycle its terminating space is accepted, updating stack and depth on that same clock edge (latency 1 cycle from the space to depth).
REQ-016 SHALL, on committing an opener with depth < MAX_DEPTH, push its type and increment depth.
REQ-017 SHALL, on committing an opener with depth == MAX_DEPTH, set error with err_code=11 and leave depth unchanged.
REQ-018 SHALL, on committing a closer with depth == 0, set error with err_code=01.
REQ-019 SHALL, on committing a closer whose type differs from the top-of-stack type, set error with err_code=10 and leave depth unchanged.
REQ-020 SHALL, on committing a closer whose type matches the top of stack, pop and decrement depth.
REQ-021 SHALL, once error is set, freeze depth, the stack and err_code until reset, while the word matcher keeps running.
REQ-022 SHALL drive result=0 whenever error=1.
REQ-023 SHALL, with error=0 and a pending word that is an opener, drive result=0.
REQ-024 SHALL, with error=0 and a pending word that is a closer, drive result=1 only if depth==1 and the closer type equals the top-of-stack type.
REQ-025 SHALL, with error=0 and a pending word that is neither opener nor closer (including IDLE), drive result=1 only if depth==0.
REQ-026 SHALL keep depth arithmetic within DEPTH_W bits, with no wrap-around possible because of REQ-017 and REQ-018.

Reset
REQ-027 SHALL, on reset low, asynchronously clear the matcher to IDLE, depth to 0, all stack entries to 0, error to 0 and err_code to 00, so that result=1 is seen immediately.
REQ-028 SHALL discard any partial word and all open blocks when reset is asserted mid-stream.

Structure
REQ-029 SHALL place the matcher state enumeration, the keyword type codes and the err_code values in the shared package block_nest_pkg.
REQ-030 SHALL implement the matcher as sub-module block_word_matcher, which outputs is_open, is_close and kw_type for the current word.
REQ-031 SHALL keep the stack in the top module as a MAX_DEPTH x 1-bit register array indexed by depth.

Verification
REQ-032 SHALL cover: "Begin fork join end" plus trailing space -> depth 1,2,1,0; result=1; error=0.
REQ-033 SHALL cover: "begin fork end" -> at the commit of "end", error=1, err_code=10, depth stays 2, result=0 afterwards.
REQ-034 SHALL cover: "end" plus space from reset -> error=1, err_code=01; and "begin en" -> depth=1, result=0.
REQ-035 SHALL cover: with MAX_DEPTH=2, "begin begin begin" -> the third commit gives err_code=11 and depth stays 2.
REQ-036 SHALL cover: "begin end" with no trailing space -> depth=1 and result=1; in_valid=0 with in=" " -> no commit, depth still 1.
REQ-037 SHALL cover: reset pulse low while depth=3 -> depth=0, error=0 and result=1 asynchronously, before the next clock edge.
